// File: rtl/clk_sw_pkg.sv
// Shared types and constants for the clock-switch sequencer.
package clk_sw_pkg;

    // Sequencer states; binary encoded.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SWITCH = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } sw_state_t;

    // Source encoding, identical to the mux select encoding.
    localparam logic SRC_CLK1 = 1'b1;
    localparam logic SRC_CLK2 = 1'b0;

    // Default parameter values.
    localparam int   DEF_DET_WIN    = 64;
    localparam int   DEF_MIN_EDGES  = 4;
    localparam int   DEF_SETTLE_CYC = 16;
    localparam logic DEF_RST_SEL    = SRC_CLK1;

endpackage

// File: rtl/hb_activity_det.sv
// Heartbeat activity detector: counts toggles of a synchronized heartbeat
// inside a fixed window and flags whether the source clock is alive.
module hb_activity_det
    import clk_sw_pkg::*;
#(
    parameter int DET_WIN   = DEF_DET_WIN,
    parameter int MIN_EDGES = DEF_MIN_EDGES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hb,
    output logic alive,
    output logic expired
);

    localparam int WW = $clog2(DET_WIN + 1);
    localparam int EW = $clog2(MIN_EDGES + 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(DET_WIN - 1);
    localparam logic [EW-1:0] EDGE_MAX  = EW'(MIN_EDGES);
    localparam logic [EW-1:0] EDGE_LAST = EW'(MIN_EDGES - 1);

    logic          hb_prev;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] edge_cnt;
    logic          edge_seen;

    assign edge_seen = hb ^ hb_prev;

    // The edge that completes the count is reported in the same cycle it is seen.
    assign alive   = (edge_cnt == EDGE_MAX) || (edge_seen && (edge_cnt == EDGE_LAST));
    assign expired = (win_cnt == WIN_LAST);

    // History and counters; clr restarts the window and re-seeds the history
    // with the current heartbeat so a stale level never counts as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_prev  <= 1'b0;
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (clr) begin
            hb_prev  <= hb;
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            hb_prev <= hb;
            if (win_cnt != WIN_LAST) begin
                win_cnt <= win_cnt + WW'(1);
            end
            if (edge_seen && (edge_cnt != EDGE_MAX)) begin
                edge_cnt <= edge_cnt + EW'(1);
            end
        end
    end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Control-side sequencer for a glitch-free clock mux: verifies the target
// clock is toggling, moves sel, waits for the handover, reports done/err.
//
// Request handshake: a request transfers on a clock edge where
// req_valid && req_ready; req_ready is high only while idle, and req_src is
// sampled on that same edge. A held req_valid is taken on the first idle cycle.
module clk_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int   DET_WIN    = DEF_DET_WIN,
    parameter int   MIN_EDGES  = DEF_MIN_EDGES,
    parameter int   SETTLE_CYC = DEF_SETTLE_CYC,
    parameter logic RST_SEL    = DEF_RST_SEL
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      req_valid,
    input  logic      req_src,
    output logic      req_ready,
    input  logic      hb1_sync,
    input  logic      hb2_sync,
    output logic      sel,
    output logic      cur_src,
    output logic      busy,
    output logic      done,
    output logic      err,
    output sw_state_t state_dbg
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    sw_state_t     state;
    logic          target;
    logic [SW-1:0] settle_cnt;
    logic          det_src;
    logic          det_hb;
    logic          det_clr;
    logic          det_alive;
    logic          det_expired;

    // While idle the detector follows the incoming request so its history is
    // already primed for the source being asked for on the accept edge.
    assign det_src   = (state == ST_IDLE) ? req_src : target;
    assign det_hb    = (det_src == SRC_CLK1) ? hb1_sync : hb2_sync;
    assign det_clr   = (state == ST_IDLE);
    assign state_dbg = state;

    hb_activity_det #(
        .DET_WIN   (DET_WIN),
        .MIN_EDGES (MIN_EDGES)
    ) u_det (
        .clk     (clk),
        .rst     (rst),
        .clr     (det_clr),
        .hb      (det_hb),
        .alive   (det_alive),
        .expired (det_expired)
    );

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            target     <= RST_SEL;
            settle_cnt <= '0;
            sel        <= RST_SEL;
            cur_src    <= RST_SEL;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_src == cur_src) begin
                            state <= ST_DONE;
                        end else begin
                            target <= req_src;
                            state  <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (det_alive) begin
                        state <= ST_SWITCH;
                    end else if (det_expired) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end
                end
                ST_SWITCH: begin
                    sel        <= target;
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_DONE: begin
                    cur_src   <= sel;
                    done      <= 1'b1;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                ST_ERR: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: precomputed stimulus timeline, a transaction
// level model that derives per-cycle expected outputs, a per-cycle compare
// process, and a directed reset-during-settle sequence.
module tb_clk_switch_ctrl;
    import clk_sw_pkg::*;

    localparam int   D  = 64;
    localparam int   ME = 4;
    localparam int   SC = 16;
    localparam logic RS = 1'b1;
    localparam int   N  = 6000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_valid = 1'b0;
    logic req_src = 1'b0;
    logic hb1_sync = 1'b0;
    logic hb2_sync = 1'b0;
    logic req_ready, sel, cur_src, busy, done, err;
    sw_state_t state_dbg;

    bit v_valid[N];
    bit v_src[N];
    bit v_hb1[N];
    bit v_hb2[N];
    bit e_sel[N];
    bit e_cur[N];
    bit e_busy[N];
    bit e_ready[N];
    bit e_done[N];
    bit e_err[N];

    int cyc = 0;
    bit run_phase = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    clk_switch_ctrl #(
        .DET_WIN    (D),
        .MIN_EDGES  (ME),
        .SETTLE_CYC (SC),
        .RST_SEL    (RS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_src   (req_src),
        .req_ready (req_ready),
        .hb1_sync  (hb1_sync),
        .hb2_sync  (hb2_sync),
        .sel       (sel),
        .cur_src   (cur_src),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input int at, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0d: got %b expected %b", name, at, act, exp);
        end
    endtask

    // per-cycle compare against the model timeline
    always @(negedge clk) begin
        if (run_phase) begin
            chk("sel", cyc, sel, e_sel[cyc]);
            chk("cur_src", cyc, cur_src, e_cur[cyc]);
            chk("busy", cyc, busy, e_busy[cyc]);
            chk("req_ready", cyc, req_ready, e_ready[cyc]);
            chk("done", cyc, done, e_done[cyc]);
            chk("err", cyc, err, e_err[cyc]);
        end
    end

    initial begin
        int c, t, m, n, hi, sw_at, md1, md2, vmode, k;
        bit tgt, m_sel, m_cur, h_now, h_prev, h1, h2, seen;

        // ---------------- stimulus timeline ----------------
        h1 = 1'b0;
        h2 = 1'b0;
        md1 = 1;
        md2 = 1;
        vmode = 0;
        for (int x = 0; x < N; x++) begin
            v_valid[x] = 1'b0;
            v_src[x]   = 1'b0;
            if (x < 100) begin
                v_hb1[x] = ((x / 5) % 2) == 1;
                v_hb2[x] = 1'b0;
            end else if (x < 200) begin
                v_hb1[x] = ((x / 5) % 2) == 1;
                v_hb2[x] = (((x - 100) / 4) % 2) == 1;
            end else if (x < 500) begin
                v_hb1[x] = ((x / 3) % 2) == 1;
                v_hb2[x] = ((x / 3) % 2) == 1;
                if (x < 400) v_valid[x] = 1'b1;
            end else begin
                if (((x - 500) % 250) == 0) begin
                    md1   = $urandom_range(0, 2);
                    md2   = $urandom_range(0, 2);
                    vmode = $urandom_range(0, 1);
                end
                if ((md1 == 1 && $urandom_range(0, 1) == 0) || (md1 == 2 && $urandom_range(0, 15) == 0)) h1 = ~h1;
                if ((md2 == 1 && $urandom_range(0, 1) == 0) || (md2 == 2 && $urandom_range(0, 15) == 0)) h2 = ~h2;
                v_hb1[x] = h1;
                v_hb2[x] = h2;
                if (x < N - 300) begin
                    v_valid[x] = (vmode == 1) ? 1'b1 : ($urandom_range(0, 9) == 0);
                    v_src[x]   = $urandom_range(0, 1) == 1;
                end
            end
        end
        v_valid[10]  = 1'b1; v_src[10]  = 1'b0;  // dead target
        v_valid[100] = 1'b1; v_src[100] = 1'b0;  // alive target
        v_valid[150] = 1'b1; v_src[150] = 1'b0;  // no-op

        // ---------------- reference model ----------------
        m_sel = RS;
        m_cur = RS;
        c = 0;
        while (c < N) begin
            if (c >= 200 && c < 400) v_src[c] = ~m_cur;
            e_sel[c]   = m_sel;
            e_cur[c]   = m_cur;
            e_busy[c]  = 1'b0;
            e_ready[c] = 1'b1;
            if (!v_valid[c]) begin
                c++;
                continue;
            end
            t = c;
            tgt = v_src[c];
            sw_at = 0;
            if (tgt == m_cur) begin
                hi = t + 1;
            end else begin
                m = 0;
                n = 0;
                for (int kk = 1; kk <= D && t + kk < N; kk++) begin
                    h_now  = tgt ? v_hb1[t + kk]     : v_hb2[t + kk];
                    h_prev = tgt ? v_hb1[t + kk - 1] : v_hb2[t + kk - 1];
                    if (h_now != h_prev) n++;
                    if (n == ME) begin
                        m = kk;
                        break;
                    end
                end
                if (m == 0) hi = t + D + 1;
                else begin
                    hi = t + m + SC + 2;
                    sw_at = t + m + 2;
                end
            end
            for (int x = t + 1; x <= hi && x < N; x++) begin
                e_busy[x]  = 1'b1;
                e_ready[x] = 1'b0;
                e_cur[x]   = m_cur;
                e_sel[x]   = (sw_at != 0 && x >= sw_at) ? tgt : m_sel;
                if (x < 400 && x >= 200) v_src[x] = tgt;
            end
            if (tgt == m_cur || sw_at != 0) begin
                if (hi + 1 < N) e_done[hi + 1] = 1'b1;
                m_sel = tgt;
                m_cur = tgt;
            end else if (hi < N) begin
                e_err[hi] = 1'b1;
            end
            c = hi + 1;
        end

        // hand-computed pins on the model
        chk("pin_err_dead", 75, e_err[75], 1'b1);
        chk("pin_busy_dead_end", 76, e_busy[76], 1'b0);
        chk("pin_sel_before", 117, e_sel[117], 1'b1);
        chk("pin_sel_after", 118, e_sel[118], 1'b0);
        chk("pin_done_happy", 135, e_done[135], 1'b1);
        chk("pin_cur_happy", 135, e_cur[135], 1'b0);
        chk("pin_busy_noop", 151, e_busy[151], 1'b1);
        chk("pin_done_noop", 152, e_done[152], 1'b1);
        chk("pin_b2b_ready", 228, e_ready[228], 1'b0);
        chk("pin_b2b_done", 229, e_done[229], 1'b1);
        chk("pin_b2b_reaccept", 230, e_busy[230], 1'b1);

        // ---------------- asynchronous reset ----------------
        #1 rst = 1'b1;
        #1;
        chk("rst_sel", 0, sel, 1'b1);
        chk("rst_cur", 0, cur_src, 1'b1);
        chk("rst_ready", 0, req_ready, 1'b1);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        chk("rst_err", 0, err, 1'b0);
        chk("rst_state", 0, state_dbg == ST_IDLE, 1'b1);
        #20 rst = 1'b0;

        // ---------------- timeline run ----------------
        for (int x = 0; x < N; x++) begin
            @(posedge clk);
            #1;
            cyc = x;
            run_phase = 1'b1;
            req_valid = v_valid[x];
            req_src   = v_src[x];
            hb1_sync  = v_hb1[x];
            hb2_sync  = v_hb2[x];
        end
        @(posedge clk);
        #1;
        run_phase = 1'b0;
        req_valid = 1'b0;

        // ---------------- reset during settle ----------------
        #2 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_src   = 1'b0;
        k = 0;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            @(posedge clk);
            #1;
            if (busy) req_valid = 1'b0;
            if (sel == 1'b0) seen = 1'b1;
            else if (k % 2 == 0) hb2_sync = ~hb2_sync;
            k++;
        end
        chk("settle_sel_low", k, sel, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("settle_state", k, state_dbg == ST_SETTLE, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sel", k, sel, 1'b1);
        chk("midrst_cur", k, cur_src, 1'b1);
        chk("midrst_busy", k, busy, 1'b0);
        chk("midrst_ready", k, req_ready, 1'b1);
        chk("midrst_done", k, done, 1'b0);
        chk("midrst_err", k, err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int x = 0; x < 30; x++) begin
            @(negedge clk);
            chk("post_rst_done", x, done, 1'b0);
            chk("post_rst_err", x, err, 1'b0);
            chk("post_rst_sel", x, sel, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
